// File: rtl/dmem_access_ctrl_pkg.sv
// Shared types and constants for the data-memory access controller.
// The default word count is shared with the data memory model.
package dmem_access_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    STROBE,
    CAPTURE,
    DONE
  } state_e;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DBG = 1'b1;

  localparam int DMEM_WORDS = 1024;

endpackage

// File: rtl/dmem_access_ctrl_arb.sv
// Two-port grant logic: round-robin with a pointer flop,
// or fixed priority to the CPU port.
module rr_arbiter2
  import dmem_access_ctrl_pkg::*;
#(
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req0,
  input  logic req1,
  input  logic advance,
  output logic gnt0,
  output logic gnt1
);

  logic ptr;
  logic pick0;

  assign pick0 = FIXED_PRIO || (ptr == PORT_CPU);

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    unique case (1'b1)
      (req0 && !req1): gnt0 = 1'b1;
      (!req0 && req1): gnt1 = 1'b1;
      (req0 && req1): begin
        gnt0 = pick0;
        gnt1 = !pick0;
      end
      default: ;
    endcase
  end

  // Pointer always favours the port that did not just win.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= PORT_CPU;
    end else if (advance && (gnt0 || gnt1)) begin
      ptr <= gnt0 ? PORT_DBG : PORT_CPU;
    end
  end

endmodule

// File: rtl/dmem_access_ctrl.sv
// Arbitrates the data memory between the CPU and debug ports and
// sequences stable-address read levels and one-cycle write strobes.
module dmem_access_ctrl
  import dmem_access_ctrl_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int MEM_WORDS = DMEM_WORDS,
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              err0,
  output logic              err1,
  output logic [ADDR_W-1:0] memAddr,
  output logic [DATA_W-1:0] memDataIn,
  output logic              memRead,
  output logic              memWrite,
  input  logic [DATA_W-1:0] memData,
  output logic              busy
);

  // One extra bit so the full address is compared without wrap.
  localparam logic [ADDR_W:0] LIMIT =
    (ADDR_W+1)'(MEM_WORDS);

  state_e state;
  logic   port;
  logic   we_q;
  logic   gnt0;
  logic   gnt1;
  logic   granted;

  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              in_range;

  rr_arbiter2 #(
    .FIXED_PRIO(FIXED_PRIO)
  ) u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .req0   (req0),
    .req1   (req1),
    .advance(state == IDLE),
    .gnt0   (gnt0),
    .gnt1   (gnt1)
  );

  assign granted   = gnt0 || gnt1;
  assign sel_we    = gnt1 ? we1 : we0;
  assign sel_addr  = gnt1 ? addr1 : addr0;
  assign sel_wdata = gnt1 ? wdata1 : wdata0;
  assign in_range  = {1'b0, sel_addr} < LIMIT;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      port      <= PORT_CPU;
      we_q      <= 1'b0;
      memAddr   <= '0;
      memDataIn <= '0;
      memRead   <= 1'b0;
      memWrite  <= 1'b0;
      ack0      <= 1'b0;
      ack1      <= 1'b0;
      err0      <= 1'b0;
      err1      <= 1'b0;
      rdata0    <= '0;
      rdata1    <= '0;
      busy      <= 1'b0;
    end else begin
      ack0     <= 1'b0;
      ack1     <= 1'b0;
      err0     <= 1'b0;
      err1     <= 1'b0;
      memWrite <= 1'b0;
      unique case (state)
        IDLE: begin
          if (granted) begin
            port      <= gnt1;
            we_q      <= sel_we;
            memAddr   <= sel_addr;
            memDataIn <= sel_wdata;
            busy      <= 1'b1;
            if (in_range) begin
              state   <= SETUP;
              memRead <= !sel_we;
            end else begin
              // Rejected: ack with err, memory untouched.
              state <= DONE;
              ack0  <= gnt0;
              ack1  <= gnt1;
              err0  <= gnt0;
              err1  <= gnt1;
            end
          end
        end
        SETUP: begin
          if (we_q) begin
            state    <= STROBE;
            memWrite <= 1'b1;
          end else begin
            state <= CAPTURE;
          end
        end
        STROBE: begin
          state <= DONE;
          ack0  <= (port == PORT_CPU);
          ack1  <= (port == PORT_DBG);
        end
        CAPTURE: begin
          state   <= DONE;
          memRead <= 1'b0;
          ack0    <= (port == PORT_CPU);
          ack1    <= (port == PORT_DBG);
          if (port == PORT_DBG) begin
            rdata1 <= memData;
          end else begin
            rdata0 <= memData;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state   <= IDLE;
          busy    <= 1'b0;
          memRead <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed and randomized checks of dmem_access_ctrl against a
// transaction-level reference model and a word-array memory.
module tb_dmem_access_ctrl;

  typedef struct {
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
  } op_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        req0, req1, we0, we1;
  logic [31:0] addr0, addr1, wdata0, wdata1;
  logic        ack0, ack1, err0, err1;
  logic [31:0] rdata0, rdata1;
  logic [31:0] memAddr, memDataIn, memData;
  logic        memRead, memWrite, busy;

  logic        f_req0, f_req1;
  logic        f_ack0, f_ack1, f_err0, f_err1;
  logic [31:0] f_rdata0, f_rdata1, f_maddr, f_mdin;
  logic        f_mrd, f_mwr, f_busy;
  logic [31:0] f_mdata;
  assign f_mdata = 32'h5A5A5A5A;

  logic [31:0] mem [0:1023] = '{default: 32'h0};
  int wr_count = 0;
  int wr_oob = 0;
  int rd_cycles = 0;

  assign memData = (memAddr < 32'd1024) ?
    mem[memAddr[9:0]] : 32'hBAD0BAD0;

  always @(posedge memWrite) begin
    if (memAddr >= 32'd1024) wr_oob++;
    else mem[memAddr[9:0]] = memDataIn;
    wr_count++;
  end

  always @(posedge clk) begin
    if (memRead === 1'b1) rd_cycles++;
  end

  dmem_access_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1),
    .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1),
    .rdata0(rdata0), .rdata1(rdata1),
    .err0(err0), .err1(err1),
    .memAddr(memAddr), .memDataIn(memDataIn),
    .memRead(memRead), .memWrite(memWrite),
    .memData(memData), .busy(busy)
  );

  dmem_access_ctrl #(.FIXED_PRIO(1'b1)) u_fix (
    .clk(clk), .rst_n(rst_n),
    .req0(f_req0), .req1(f_req1),
    .we0(1'b0), .we1(1'b0),
    .addr0(32'd3), .addr1(32'd4),
    .wdata0(32'd0), .wdata1(32'd0),
    .ack0(f_ack0), .ack1(f_ack1),
    .rdata0(f_rdata0), .rdata1(f_rdata1),
    .err0(f_err0), .err1(f_err1),
    .memAddr(f_maddr), .memDataIn(f_mdin),
    .memRead(f_mrd), .memWrite(f_mwr),
    .memData(f_mdata), .busy(f_busy)
  );

  int errors = 0;
  int checks = 0;

  logic [31:0] ref_mem [0:1023] = '{default: 32'h0};
  logic        ref_ptr = 1'b0;
  logic [31:0] sv0 = 32'h0;
  logic [31:0] sv1 = 32'h0;
  op_t         q0[$];
  op_t         q1[$];
  logic        ack_log[$];
  logic        exp_log[$];

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic check_b(input string tag,
                         input logic obs,
                         input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %b want %b", tag, obs, exp);
    end
  endtask

  function automatic op_t mk(input logic w,
                             input logic [31:0] a,
                             input logic [31:0] d);
    op_t o;
    o.w = w;
    o.a = a;
    o.d = d;
    return o;
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic drive(input logic p, input logic r,
                       input op_t op);
    if (p) begin
      req1 = r; we1 = op.w; addr1 = op.a; wdata1 = op.d;
    end else begin
      req0 = r; we0 = op.w; addr0 = op.a; wdata0 = op.d;
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 16 && busy !== 1'b0; i++) tick();
    check_b("idle_wait", busy, 1'b0);
  endtask

  // Result of one acked transaction versus the reference model.
  task automatic finish_op(input logic p, input op_t op);
    logic        oob;
    logic [31:0] e;
    oob = (op.a >= 32'd1024);
    check_b("ack_excl", p ? ack0 : ack1, 1'b0);
    check_b("err", p ? err1 : err0, oob);
    check("other_rdata", p ? rdata0 : rdata1,
          p ? sv0 : sv1);
    if (!op.w && !oob) e = ref_mem[op.a[9:0]];
    else e = p ? sv1 : sv0;
    check(op.w ? "rdata_keep" : "rdata",
          p ? rdata1 : rdata0, e);
    if (p) sv1 = e;
    else sv0 = e;
    if (op.w && !oob) ref_mem[op.a[9:0]] = op.d;
    ref_ptr = !p;
    ack_log.push_back(p);
  endtask

  task automatic do_op(input logic p, input op_t op,
                       input string tag);
    int          lat, wpos, wc, rc;
    logic [31:0] ma;
    logic        oob;
    wait_idle();
    oob = (op.a >= 32'd1024);
    wc = wr_count;
    rc = rd_cycles;
    lat = 0;
    wpos = 0;
    ma = 32'h0;
    drive(p, 1'b1, op);
    for (int n = 1; n <= 8; n++) begin
      tick();
      if (memWrite) begin
        wpos = n;
        ma = memAddr;
      end
      if (p ? ack1 : ack0) begin
        lat = n;
        break;
      end
    end
    check({tag, "_lat"}, lat, oob ? 1 : 3);
    if (lat != 0) finish_op(p, op);
    drive(p, 1'b0, op);
    check({tag, "_wr"}, wr_count - wc,
          (op.w && !oob) ? 1 : 0);
    check({tag, "_rd"}, rd_cycles - rc,
          (!op.w && !oob) ? 2 : 0);
    if (op.w && !oob) begin
      check({tag, "_wpos"}, wpos, 2);
      check({tag, "_waddr"}, ma, op.a);
    end
  endtask

  // Both ports present queued ops; a port re-requests at its ack.
  task automatic engine(input int start1, input int max_cyc);
    op_t  c0, c1;
    logic a0, a1;
    int   cyc;
    a0 = 1'b0;
    a1 = 1'b0;
    cyc = 0;
    ack_log.delete();
    while ((q0.size() > 0 || q1.size() > 0 || a0 || a1)
           && cyc < max_cyc) begin
      if (!a0 && q0.size() > 0) begin
        c0 = q0.pop_front();
        a0 = 1'b1;
        drive(1'b0, 1'b1, c0);
      end
      if (!a1 && q1.size() > 0 && cyc >= start1) begin
        c1 = q1.pop_front();
        a1 = 1'b1;
        drive(1'b1, 1'b1, c1);
      end
      tick();
      cyc++;
      if (ack0) check_b("ack0_expected", ack0, a0);
      if (ack1) check_b("ack1_expected", ack1, a1);
      if (ack0 && a0) begin
        finish_op(1'b0, c0);
        a0 = 1'b0;
        drive(1'b0, 1'b0, c0);
      end
      if (ack1 && a1) begin
        finish_op(1'b1, c1);
        a1 = 1'b0;
        drive(1'b1, 1'b0, c1);
      end
    end
    check_b("engine_timeout", a0 || a1 ||
            q0.size() > 0 || q1.size() > 0, 1'b0);
  endtask

  task automatic check_order(input string tag);
    check({tag, "_n"}, ack_log.size(), exp_log.size());
    for (int i = 0; i < exp_log.size(); i++) begin
      if (i < ack_log.size())
        check_b({tag, "_port"}, ack_log[i], exp_log[i]);
    end
  endtask

  initial begin
    int          wc, rc, n0, n1, acks;
    logic        p;
    logic [31:0] a;

    rst_n = 1'b1;
    req0 = 0; req1 = 0; we0 = 0; we1 = 0;
    addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
    f_req0 = 0; f_req1 = 0;
    #2 rst_n = 1'b0;
    repeat (3) tick();

    check_b("rst_ack0", ack0, 1'b0);
    check_b("rst_ack1", ack1, 1'b0);
    check_b("rst_err0", err0, 1'b0);
    check_b("rst_err1", err1, 1'b0);
    check_b("rst_mrd", memRead, 1'b0);
    check_b("rst_mwr", memWrite, 1'b0);
    check_b("rst_busy", busy, 1'b0);
    check("rst_rdata0", rdata0, 32'h0);
    check("rst_rdata1", rdata1, 32'h0);
    check("rst_maddr", memAddr, 32'h0);
    check("rst_mdin", memDataIn, 32'h0);
    rst_n = 1'b1;
    tick();
    check_b("post_rst_busy", busy, 1'b0);

    do_op(1'b0, mk(1'b1, 32'd5, 32'hDEADBEEF), "wr5");
    do_op(1'b0, mk(1'b0, 32'd5, 32'h0), "rd5");
    check("rd5_value", rdata0, 32'hDEADBEEF);

    // Req dropped after ack: controller goes quiet.
    wc = wr_count;
    rc = rd_cycles;
    tick();
    check_b("drop_busy", busy, 1'b0);
    acks = 0;
    repeat (4) begin
      tick();
      acks += int'(ack0) + int'(ack1);
    end
    check("drop_acks", acks, 0);
    check("drop_wr", wr_count - wc, 0);
    check("drop_rd", rd_cycles - rc, 0);
    check_b("drop_busy2", busy, 1'b0);

    do_op(1'b0, mk(1'b1, 32'd1, 32'h11111111), "wr1");
    do_op(1'b1, mk(1'b1, 32'd2, 32'h22222222), "wr2");

    // Simultaneous reads with pointer at port 0.
    q0.push_back(mk(1'b0, 32'd1, 32'h0));
    q1.push_back(mk(1'b0, 32'd2, 32'h0));
    exp_log = '{1'b0, 1'b1};
    engine(0, 40);
    check_order("dual");
    check("dual_rd0", rdata0, 32'h11111111);
    check("dual_rd1", rdata1, 32'h22222222);

    // Port 0 keeps requesting; port 1 arrives once.
    q0.push_back(mk(1'b0, 32'd5, 32'h0));
    q0.push_back(mk(1'b0, 32'd1, 32'h0));
    q1.push_back(mk(1'b0, 32'd2, 32'h0));
    exp_log = '{1'b0, 1'b1, 1'b0};
    engine(2, 60);
    check_order("rr");

    // Address range boundaries.
    do_op(1'b1, mk(1'b1, 32'd1024, 32'h12345678), "oob_wr");
    do_op(1'b0, mk(1'b0, 32'd0, 32'h0), "rd0");
    do_op(1'b0, mk(1'b0, 32'h80000005, 32'h0), "oob_hi");
    do_op(1'b1, mk(1'b0, 32'hFFFFFFFF, 32'h0), "oob_max");
    do_op(1'b1, mk(1'b1, 32'd1023, 32'hA5A5A5A5), "wr_top");
    do_op(1'b0, mk(1'b0, 32'd1023, 32'h0), "rd_top");
    check("top_value", rdata0, 32'hA5A5A5A5);
    check("oob_no_wr", wr_oob, 0);
    check("mem0_kept", mem[0], 32'h0);

    // Reset while the write strobe is high.
    wait_idle();
    drive(1'b0, 1'b1, mk(1'b1, 32'd7, 32'h00C0FFEE));
    tick();
    tick();
    check_b("strobe_seen", memWrite, 1'b1);
    wc = wr_count;
    rst_n = 1'b0;
    #1;
    check_b("rst_mid_mwr", memWrite, 1'b0);
    check_b("rst_mid_mrd", memRead, 1'b0);
    check_b("rst_mid_busy", busy, 1'b0);
    check_b("rst_mid_ack0", ack0, 1'b0);
    drive(1'b0, 1'b0, mk(1'b0, 32'd0, 32'h0));
    tick();
    rst_n = 1'b1;
    ref_mem[7] = 32'h00C0FFEE;
    ref_ptr = 1'b0;
    sv0 = 32'h0;
    sv1 = 32'h0;
    acks = 0;
    repeat (6) begin
      tick();
      acks += int'(ack0) + int'(ack1);
    end
    check("rst_mid_acks", acks, 0);
    check("rst_mid_wr", wr_count - wc, 0);
    do_op(1'b0, mk(1'b0, 32'd7, 32'h0), "rd7");
    check("rd7_value", rdata0, 32'h00C0FFEE);

    // Random traffic, both ports always requesting.
    exp_log.delete();
    p = ref_ptr;
    for (int i = 0; i < 16; i++) begin
      for (int k = 0; k < 2; k++) begin
        if ($urandom_range(0, 7) == 0)
          a = 32'd1024 + $urandom_range(0, 64);
        else
          a = $urandom_range(0, 15);
        if (k == 0)
          q0.push_back(mk($urandom_range(0, 1) == 1,
                          a, $urandom));
        else
          q1.push_back(mk($urandom_range(0, 1) == 1,
                          a, $urandom));
      end
    end
    for (int i = 0; i < 32; i++) begin
      exp_log.push_back(p);
      p = !p;
    end
    engine(0, 600);
    check_order("rand");
    check("rand_no_oob_wr", wr_oob, 0);

    // Fixed priority: port 1 starves while port 0 holds req.
    f_req0 = 1'b1;
    f_req1 = 1'b1;
    n0 = 0;
    n1 = 0;
    repeat (40) begin
      tick();
      n0 += int'(f_ack0);
      n1 += int'(f_ack1);
    end
    check("fix_n1", n1, 0);
    check("fix_n0", n0, 10);
    f_req0 = 1'b0;
    for (int i = 0; i < 8 && n1 == 0; i++) begin
      tick();
      if (f_ack1) begin
        n1++;
        f_req1 = 1'b0;
      end
    end
    check("fix_dbg_served", n1, 1);
    check("fix_rdata1", f_rdata1, 32'h5A5A5A5A);
    check("fix_rdata0", f_rdata0, 32'h5A5A5A5A);
    f_req1 = 1'b0;

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule

// File: doc/dmem_access_ctrl.md
Name: dmem_access_ctrl

Overview:
- Sequences and arbitrates the single data memory between two requesters: port 0 is the CPU load/store unit and port 1 is the debug/loader port.
- Turns level req/ack handshakes into the memory's stable-address strobes: a registered memRead level, and a one-cycle registered memWrite pulse, since the memory writes on the memWrite rising edge.
- Captures read data into a register before acknowledging the requester.
- Sits between the multicycle control/datapath and the data memory.

Parameters:
- ADDR_W, 32, address width of requesters and memory
- DATA_W, 32, data width
- MEM_WORDS, 1024, number of valid word addresses; any address >= MEM_WORDS is out of range
- FIXED_PRIO, 0, 1 = port 0 always wins; 0 = round-robin

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req0, req1  in  1  request level; held with we/addr/wdata stable until the matching ack
- we0, we1  in  1  1 = write, 0 = read
- addr0, addr1  in  ADDR_W  word address
- wdata0, wdata1  in  DATA_W  write data
- ack0, ack1  out  1  one-cycle completion pulse
- rdata0, rdata1  out  DATA_W  registered read data; valid from ack until that port's next ack
- err0, err1  out  1  with ack: address out of range, no memory access made
- memAddr  out  ADDR_W  registered address to memory
- memDataIn  out  DATA_W  registered write data to memory
- memRead  out  1  registered read enable
- memWrite  out  1  registered write strobe, one cycle high
- memData  in  DATA_W  combinational read data from memory
- busy  out  1  state != IDLE

Behaviour:
- All outputs come from flops. Reset state: IDLE, all outputs 0, round-robin pointer = port 0 preferred.
- States: IDLE, SETUP, STROBE, CAPTURE, DONE.
- IDLE:
  - Sample req0/req1 and pick a winner.
  - Round-robin: if both request, the pointer port wins; the pointer then moves to the non-winner. If one requests, it wins. The pointer updates only on a grant.
  - On grant, latch port id, we, addr and wdata into memAddr/memDataIn. Then go to SETUP, or go to DONE with err=1 if addr >= MEM_WORDS.
- SETUP (1 cycle): address/data are stable at memory. memRead=1 if read. Next state: STROBE for a write, CAPTURE for a read.
- STROBE (1 cycle): memWrite=1. Next state: DONE. memWrite is low in every other state, so exactly one rising edge occurs per write.
- CAPTURE (1 cycle): memRead=1; register memData into the winner's rdata. Next state: DONE.
- DONE (1 cycle): ack of the winner =1, err as latched, memRead=0. Next state: IDLE.
- Latency from the cycle req is sampled in IDLE to the ack cycle:
  - write: 3 cycles
  - read: 3 cycles
  - error: 1 cycle
- Requester rules:
  - A requester may drop req in the cycle after ack.
  - A req still high in the IDLE cycle after DONE starts a new transaction.
  - Dropping req mid-transaction does not abort it; the transaction still completes and acks.
- Simultaneous requests: exactly one port is granted per transaction; the loser waits, and neither port is ever acked twice for one grant.
- Starvation: with FIXED_PRIO=0, a continuously requesting port is granted within 2 transactions.
- Ack exclusivity: ack0 and ack1 are never high together. The rdata of the non-winning port is unchanged.
- Reset mid-operation: async return to IDLE. memWrite and memRead drop immediately, and memWrite is never raised after reset, so no spurious write occurs. No ack is issued for the aborted transaction.
- Address width: MEM_WORDS is compared against the full ADDR_W address; no truncation or wrap-around.

Decomposition:
- Shared package:
  - state enum (IDLE, SETUP, STROBE, CAPTURE, DONE)
  - port-id constants PORT_CPU=0, PORT_DBG=1
  - default MEM_WORDS constant, shared with the data memory
- Sub-module rr_arbiter2: 2-input round-robin/fixed-priority grant with pointer flop. Inputs: req0, req1, advance, FIXED_PRIO. Outputs: gnt0, gnt1.

Test Plan:
- Single write, port 0 (addr=5, wdata=0xDEADBEEF): memWrite is high exactly one cycle at IDLE+2 with memAddr=5; ack0 at IDLE+3. A following read of addr 5 returns rdata0=0xDEADBEEF with ack0 3 cycles after sampling.
- Both ports request reads in the same cycle (addr0=1, addr1=2), pointer=0: port 0 is served first, then port 1. ack0 and ack1 are never coincident; rdata1 is unchanged until ack1.
- Port 0 requests continuously while port 1 issues one request: ack sequence is 0,1,0 (round-robin). With FIXED_PRIO=1, port 1 is never acked while req0 is held.
- Out-of-range: port 1 writes addr=1024. Ack1 and err1 go high 1 cycle after sampling; memWrite and memRead never assert; memory contents are unchanged.
- rst_n asserted during STROBE of a write: memWrite falls immediately, no ack is issued, busy=0. After release, a fresh read returns the prior contents or the written value consistently, with no second write edge.
- Requester drops req the cycle after ack: busy=0 the next cycle and no further memory strobes occur.
